// File: rtl/fnd_pkg.sv
// Shared types and helpers for the FND display arbiter.
package fnd_pkg;

  localparam int VALUE_W = 14;
  localparam logic [VALUE_W-1:0] DISP_MAX = 14'd9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  // Clamp a raw 14-bit value to what four decimal digits can show.
  function automatic logic [VALUE_W-1:0] sat_disp(input logic [VALUE_W-1:0] x);
    return (x > DISP_MAX) ? DISP_MAX : x;
  endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Free-running divider: one-cycle o_tick every TICK_MAX clocks.
module fnd_tick_gen #(
  parameter int TICK_MAX = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_MAX - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  // Count 0..TICK_MAX-1 and wrap; the pulse is the terminal count itself.
  always_ff @(posedge clk) begin
    if (!reset)      r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/fnd_display_arbiter.sv
// Round-robin owner of the 4-digit FND value path with a per-owner hold window.
module fnd_display_arbiter
  import fnd_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int TICK_MAX = 100000,
  parameter int HOLD_MS  = 1000,
  localparam int OW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*VALUE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [VALUE_W-1:0]         disp_value,
  output logic [OW-1:0]              disp_owner,
  output logic                       disp_blank,
  output logic                       owner_change
);

  localparam int HW = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;

  arb_state_t          r_state, w_next;
  logic [OW-1:0]       r_grant, r_rr_last, r_disp_owner;
  logic [VALUE_W-1:0]  r_disp_value;
  logic                r_disp_blank, r_owner_change;
  logic [HW-1:0]       r_hold;

  logic                w_tick, w_any, w_others, w_expire, w_found;
  logic [OW-1:0]       w_base, w_win;
  logic [NUM_REQ-1:0]  w_owner_mask;
  logic [VALUE_W-1:0]  w_grant_data, w_owner_data;

  fnd_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
    .clk   (clk),
    .reset (reset),
    .o_tick(w_tick)
  );

  assign w_owner_mask = NUM_REQ'(1) << r_disp_owner;
  assign w_any        = |req_valid;
  assign w_others     = |(req_valid & ~w_owner_mask);
  assign w_expire     = (r_state == HOLD) && w_tick && (r_hold == HW'(HOLD_MS - 1));
  assign w_grant_data = req_data[VALUE_W*int'(r_grant) +: VALUE_W];
  assign w_owner_data = req_data[VALUE_W*int'(r_disp_owner) +: VALUE_W];

  // Round-robin search: first valid requester after the base, wrapping.
  // In HOLD the search starts after the owner so it lands on the owner last.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    w_base  = (r_state == HOLD) ? r_disp_owner : r_rr_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(w_base) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = OW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and ready decode.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      IDLE: if (w_any) w_next = LOAD;
      LOAD: begin
        req_ready = NUM_REQ'(1) << r_grant;
        w_next    = req_valid[r_grant] ? HOLD : IDLE;
      end
      HOLD: begin
        req_ready = w_owner_mask;
        if (w_expire) begin
          if (w_others)                     w_next = LOAD;
          else if (!req_valid[r_disp_owner]) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Grant, display value, ownership and hold-window bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant        <= '0;
      r_rr_last      <= OW'(NUM_REQ - 1);
      r_disp_value   <= '0;
      r_disp_owner   <= '0;
      r_disp_blank   <= 1'b1;
      r_owner_change <= 1'b0;
      r_hold         <= '0;
    end else begin
      r_owner_change <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_grant   <= w_win;
          r_rr_last <= w_win;
        end
        LOAD: if (req_valid[r_grant]) begin
          r_disp_value   <= sat_disp(w_grant_data);
          r_disp_blank   <= 1'b0;
          r_disp_owner   <= r_grant;
          r_owner_change <= (r_grant != r_disp_owner) || r_disp_blank;
          r_hold         <= '0;
        end
        HOLD: begin
          // Owner updates never restart the window.
          if (req_valid[r_disp_owner]) r_disp_value <= sat_disp(w_owner_data);
          if (w_expire) begin
            if (w_others) begin
              r_grant   <= w_win;
              r_rr_last <= w_win;
            end else begin
              r_hold <= '0;
            end
          end else if (w_tick) begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign disp_value   = r_disp_value;
  assign disp_owner   = r_disp_owner;
  assign disp_blank   = r_disp_blank;
  assign owner_change = r_owner_change;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed + random bench for fnd_display_arbiter against a behavioural model.
module tb_fnd_display_arbiter;

  localparam int N    = 2;
  localparam int TICK = 4;
  localparam int HOLD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*14-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [13:0]   disp_value;
  logic [0:0]    disp_owner;
  logic          disp_blank;
  logic          owner_change;

  int total = 0;
  int bad   = 0;

  // model state: phase 0=idle 1=load 2=hold
  int m_ph, m_val, m_owner, m_blank, m_oc, m_ticks, m_cyc, m_last, m_grant;

  fnd_display_arbiter #(.NUM_REQ(N), .TICK_MAX(TICK), .HOLD_MS(HOLD)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .disp_value(disp_value), .disp_owner(disp_owner),
    .disp_blank(disp_blank), .owner_change(owner_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int data_of(input int i);
    return int'(req_data[14*i +: 14]);
  endfunction

  // Next valid requester after 'from' in circular order.
  function automatic int next_valid(input int from);
    for (int k = 1; k <= N; k++)
      if (req_valid[(from + k) % N]) return (from + k) % N;
    return from;
  endfunction

  task automatic model_edge();
    bit tick;
    bit others;
    if (!reset) begin
      m_ph = 0; m_val = 0; m_owner = 0; m_blank = 1; m_oc = 0;
      m_ticks = 0; m_cyc = 0; m_last = N - 1; m_grant = 0;
      return;
    end
    tick = (m_cyc % TICK) == TICK - 1;
    m_cyc++;
    m_oc = 0;
    if (m_ph == 0) begin
      if (req_valid != 0) begin
        m_grant = next_valid(m_last); m_last = m_grant; m_ph = 1;
      end
    end else if (m_ph == 1) begin
      if (req_valid[m_grant]) begin
        m_oc = (m_grant != m_owner) || m_blank;
        m_val = sat(data_of(m_grant)); m_blank = 0; m_owner = m_grant;
        m_ticks = 0; m_ph = 2;
      end else m_ph = 0;
    end else begin
      if (req_valid[m_owner]) m_val = sat(data_of(m_owner));
      if (tick) begin
        if (m_ticks == HOLD - 1) begin
          others = 0;
          for (int i = 0; i < N; i++) if (i != m_owner && req_valid[i]) others = 1;
          if (others) begin
            m_grant = next_valid(m_owner); m_last = m_grant; m_ph = 1;
          end else if (req_valid[m_owner]) m_ticks = 0;
          else m_ph = 0;
        end else m_ticks++;
      end
    end
  endtask

  task automatic check_model();
    int er;
    er = (m_ph == 1) ? (1 << m_grant) : (m_ph == 2) ? (1 << m_owner) : 0;
    chk("m_value", disp_value, m_val);
    chk("m_owner", disp_owner, m_owner);
    chk("m_blank", disp_blank, m_blank);
    chk("m_ochg",  owner_change, m_oc);
    chk("m_ready", req_ready, er);
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
    end
  endtask

  task automatic set_data(input int i, input int v);
    req_data[14*i +: 14] = v[13:0];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); model_edge();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0;
    @(negedge clk);
    do_reset(); do_reset();
    check_model();
    chk("rst_blank", disp_blank, 1);
    chk("rst_value", disp_value, 0);
    chk("rst_ready", req_ready, 0);

    // single requester load
    reset = 1'b1; req_valid = 2'b01; set_data(0, 1234);
    cyc();
    chk("load_ready", req_ready, 2'b01);
    cyc();
    chk("load_value", disp_value, 1234);
    chk("load_blank", disp_blank, 0);
    chk("load_ochg",  owner_change, 1);
    chk("load_owner", disp_owner, 0);
    cyc();
    chk("ochg_pulse", owner_change, 0);
    req_valid = 2'b00;
    cyc(16);

    // both valid from reset: owner 0 first, owner 1 after 3 ticks, back again
    do_reset();
    reset = 1'b1; req_valid = 2'b11; set_data(0, 11); set_data(1, 22);
    cyc(2);
    chk("rr_first_owner", disp_owner, 0);
    chk("rr_first_val",   disp_value, 11);
    cyc(11);
    chk("rr_second_owner", disp_owner, 1);
    chk("rr_second_val",   disp_value, 22);
    cyc(12);
    chk("rr_back_owner", disp_owner, 0);
    chk("rr_back_val",   disp_value, 11);

    // owner 0 streams 5,6,7
    set_data(0, 5); cyc(); chk("stream5", disp_value, 5);
    set_data(0, 6); cyc(); chk("stream6", disp_value, 6);
    set_data(0, 7); cyc(); chk("stream7", disp_value, 7);
    cyc(8);
    chk("stream_hold_owner", disp_owner, 0);
    cyc();
    chk("stream_expiry_owner", disp_owner, 1);

    // saturation on owner 1
    set_data(1, 16383); cyc(); chk("sat_3fff", disp_value, 9999);
    set_data(1, 10000); cyc(); chk("sat_10000", disp_value, 9999);
    set_data(1, 9999);  cyc(); chk("sat_9999", disp_value, 9999);
    set_data(1, 9998);  cyc(); chk("sat_9998", disp_value, 9998);

    // requester 1 withdraws during its LOAD cycle
    do_reset();
    reset = 1'b1; req_valid = 2'b11; set_data(0, 11); set_data(1, 22);
    cyc(12);
    chk("wd_load_ready", req_ready, 2'b10);
    req_valid = 2'b01;
    cyc();
    chk("wd_idle_ready", req_ready, 0);
    chk("wd_owner", disp_owner, 0);
    chk("wd_ochg", owner_change, 0);
    cyc();
    chk("wd_regrant_ready", req_ready, 2'b01);
    cyc();
    chk("wd_regrant_ochg", owner_change, 0);
    chk("wd_regrant_val", disp_value, 11);

    // reset mid-HOLD
    req_valid = 2'b11;
    cyc(3);
    do_reset();
    check_model();
    chk("mid_rst_value", disp_value, 0);
    chk("mid_rst_blank", disp_blank, 1);
    chk("mid_rst_ready", req_ready, 0);
    reset = 1'b1;
    cyc();
    chk("mid_rst_prio", req_ready, 2'b01);
    cyc();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) req_valid = N'($urandom_range(0, 3));
      for (int r = 0; r < N; r++)
        if ($urandom_range(0, 1) == 1) set_data(r, int'($urandom & 32'h3FFF));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
